// File: rtl/clkswitch_pkg.sv
// Shared types for the CPU clock-switch sequencer: state encoding, divider codes
// and settle-counter width.
package clkswitch_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        LS_IDLE,
        HS_IDLE,
        DROP,
        DIV,
        RAISE,
        SLOW
    } state_t;

    typedef enum logic [1:0] {
        DIV1 = 2'b00,
        DIV2 = 2'b01,
        DIV4 = 2'b10,
        DIV8 = 2'b11
    } div_t;

endpackage

// File: rtl/clkswitch_if.sv
// Request / slow-access handshake and clock-controller selects of clkswitch_seq.
// switch_count exists only when CLKSWITCH_COUNT_EN is defined.
interface clkswitch_if;
    logic        req_valid;
    logic        req_hs;
    logic [1:0]  req_div;
    logic        req_ready;
    logic        slow_req;
    logic        slow_ack;
    logic        hsclk_sel;
    logic [1:0]  cpuclk_div_sel;
    logic        busy;
`ifdef CLKSWITCH_COUNT_EN
    logic [15:0] switch_count;
`endif

    modport master (
        output req_valid, req_hs, req_div, slow_req,
`ifdef CLKSWITCH_COUNT_EN
        input  switch_count,
`endif
        input  req_ready, slow_ack, hsclk_sel, cpuclk_div_sel, busy
    );

    modport slave (
        input  req_valid, req_hs, req_div, slow_req,
`ifdef CLKSWITCH_COUNT_EN
        output switch_count,
`endif
        output req_ready, slow_ack, hsclk_sel, cpuclk_div_sel, busy
    );
endinterface

// File: rtl/clkswitch_seq_settle_timer.sv
// Shared settle counter: loads N-1 on entry to a timed state, counts down, flags zero.
module settle_timer
    import clkswitch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);
endmodule

// File: rtl/clkswitch_seq.sv
// Sequences hsclk_sel / cpuclk_div_sel so the divider only moves while on the slow clock.
// Optional CLKSWITCH_COUNT_EN adds a saturating count of high-speed raises.
module clkswitch_seq
    import clkswitch_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int DIV_SETTLE    = 16
) (
    input  logic        hsclk_in,
    input  logic        rst,
    clkswitch_if.slave  bus
);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD    = CNT_W'(DIV_SETTLE - 1);

    state_t           state, state_n;
    logic             hs_n, ack_n, busy_n;
    logic [1:0]       div_n;
    logic             cfg_hs, cfg_hs_n, ret_hs, ret_hs_n;
    logic [1:0]       cfg_div, cfg_div_n;
    logic             t_load, t_zero, accept;
    logic [CNT_W-1:0] t_val;

    assign bus.req_ready = ((state == LS_IDLE) || (state == HS_IDLE)) && !bus.slow_req;
    assign accept        = bus.req_valid && bus.req_ready;
    assign busy_n        = !((state_n == LS_IDLE) || (state_n == HS_IDLE));

    settle_timer u_timer (
        .clk      (hsclk_in),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_comb begin
        state_n   = state;
        hs_n      = bus.hsclk_sel;
        div_n     = bus.cpuclk_div_sel;
        ack_n     = bus.slow_ack;
        cfg_hs_n  = cfg_hs;
        cfg_div_n = cfg_div;
        ret_hs_n  = ret_hs;
        t_load    = 1'b0;
        t_val     = SETTLE_LD;
        if (accept) begin
            cfg_hs_n  = bus.req_hs;
            cfg_div_n = bus.req_div;
        end
        unique case (state)
            LS_IDLE: begin
                ack_n = bus.slow_req;
                if (accept) begin
                    if (bus.req_div != bus.cpuclk_div_sel) begin
                        state_n = DIV;
                        div_n   = bus.req_div;
                        t_load  = 1'b1;
                        t_val   = DIV_LD;
                    end else if (bus.req_hs) begin
                        state_n = RAISE;
                        hs_n    = 1'b1;
                        t_load  = 1'b1;
                    end
                end
            end
            HS_IDLE: begin
                // A same-divider high-speed request is acked here with no sequence.
                if (bus.slow_req || (accept && !(bus.req_hs && (bus.req_div == bus.cpuclk_div_sel)))) begin
                    state_n  = DROP;
                    hs_n     = 1'b0;
                    ret_hs_n = bus.slow_req;
                    t_load   = 1'b1;
                end
            end
            DROP: begin
                if (t_zero) begin
                    if (ret_hs) begin
                        state_n = SLOW;
                        ack_n   = 1'b1;
                    end else if (cfg_div != bus.cpuclk_div_sel) begin
                        state_n = DIV;
                        div_n   = cfg_div;
                        t_load  = 1'b1;
                        t_val   = DIV_LD;
                    end else if (cfg_hs) begin
                        state_n = RAISE;
                        hs_n    = 1'b1;
                        t_load  = 1'b1;
                    end else begin
                        state_n = LS_IDLE;
                    end
                end
            end
            DIV: begin
                if (t_zero) begin
                    if (!cfg_hs) begin
                        state_n = LS_IDLE;
                    end else if (bus.slow_req) begin
                        state_n  = SLOW;
                        ret_hs_n = 1'b1;
                        ack_n    = 1'b1;
                    end else begin
                        state_n = RAISE;
                        hs_n    = 1'b1;
                        t_load  = 1'b1;
                    end
                end
            end
            SLOW: begin
                if (!bus.slow_req) begin
                    state_n  = RAISE;
                    ack_n    = 1'b0;
                    hs_n     = 1'b1;
                    ret_hs_n = 1'b0;
                    t_load   = 1'b1;
                end
            end
            RAISE: begin
                if (t_zero)
                    state_n = HS_IDLE;
            end
            default: state_n = LS_IDLE;
        endcase
    end

    always_ff @(posedge hsclk_in or posedge rst) begin
        if (rst) begin
            state              <= LS_IDLE;
            bus.hsclk_sel      <= 1'b0;
            bus.cpuclk_div_sel <= DIV8;
            bus.slow_ack       <= 1'b0;
            bus.busy           <= 1'b0;
            cfg_hs             <= 1'b0;
            cfg_div            <= DIV8;
            ret_hs             <= 1'b0;
        end else begin
            state              <= state_n;
            bus.hsclk_sel      <= hs_n;
            bus.cpuclk_div_sel <= div_n;
            bus.slow_ack       <= ack_n;
            bus.busy           <= busy_n;
            cfg_hs             <= cfg_hs_n;
            cfg_div            <= cfg_div_n;
            ret_hs             <= ret_hs_n;
        end
    end

`ifdef CLKSWITCH_COUNT_EN
    logic [15:0] switch_cnt;

    always_ff @(posedge hsclk_in or posedge rst) begin
        if (rst)
            switch_cnt <= '0;
        else if ((state_n == RAISE) && (state != RAISE) && (switch_cnt != 16'hFFFF))
            switch_cnt <= switch_cnt + 16'd1;
    end

    assign bus.switch_count = switch_cnt;
`endif
endmodule

// File: tb/tb_clkswitch_seq.sv
// Scenario bench for clkswitch_seq; uses unequal settle times so the two delays are distinguishable.
module tb_clkswitch_seq;
    import clkswitch_pkg::*;

    localparam int S      = 16;
    localparam int D      = 24;
    localparam int BUDGET = 500;

    typedef struct {
        string  tag;
        integer val;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    exp_t   exp_q[$];
    integer obs_q[$];
    int     total = 0;
    int     bad   = 0;
    int     div_viol = 0;
    int     tog_viol = 0;

    clkswitch_if bus ();

    clkswitch_seq #(.SETTLE_CYCLES(S), .DIV_SETTLE(D)) dut (
        .hsclk_in (clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Invariant monitor: divider moves only after S low cycles; hsclk_sel toggles >= S apart.
    int         low_run, since_tog;
    logic       prev_hs;
    logic [1:0] prev_div;
    always @(negedge clk) begin
        if (rst) begin
            low_run   = 1000;
            since_tog = 1000;
            prev_hs   = 1'b0;
            prev_div  = 2'b11;
        end else begin
            if (bus.cpuclk_div_sel !== prev_div && low_run < S) div_viol++;
            if (bus.hsclk_sel !== prev_hs) begin
                if (since_tog < S) tog_viol++;
                since_tog = 1;
            end else if (since_tog < 1000) begin
                since_tog++;
            end
            if (bus.hsclk_sel) low_run = 0;
            else if (low_run < 1000) low_run++;
            prev_hs  = bus.hsclk_sel;
            prev_div = bus.cpuclk_div_sel;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input integer v);
        exp_q.push_back('{tag, v});
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.hsclk_sel;
            1:       return bus.slow_ack;
            default: return bus.busy;
        endcase
    endfunction

    task automatic wait_lvl(input int sel, input logic lvl, output int n);
        n = 0;
        while (sig(sel) !== lvl && n < BUDGET) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_div(input logic [1:0] v, output int n);
        n = 0;
        while (bus.cpuclk_div_sel !== v && n < BUDGET) begin
            tick();
            n++;
        end
    endtask

    task automatic send_req(input logic hs, input logic [1:0] dv, output logic rdy0);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_hs    = hs;
        bus.req_div   = dv;
        #1 rdy0 = bus.req_ready;
        while (bus.req_ready !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
        end
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        integer o;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_hs = 1'b0; bus.req_div = 2'b00; bus.slow_req = 1'b0;
        repeat (3) tick();
        expect_v("rst_hs", 0); expect_v("rst_div", 3); expect_v("rst_ack", 0);
        expect_v("rst_busy", 0); expect_v("rst_ready", 1);
        obs_q.push_back(bus.hsclk_sel); obs_q.push_back(bus.cpuclk_div_sel);
        obs_q.push_back(bus.slow_ack); obs_q.push_back(bus.busy); obs_q.push_back(bus.req_ready);
        rst = 1'b0;
        repeat (5) tick();
        expect_v("post_rst_busy", 0);
        obs_q.push_back(bus.busy);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.val) begin bad++; $display("FAIL %s got=%0d want=%0d", e.tag, o, e.val); end
        end
    endtask

    task automatic test_ls_to_hs();
        exp_t e;
        integer o;
        int n;
        logic r;
        expect_v("up_ready", 1);
        send_req(1'b1, DIV1, r);
        obs_q.push_back(r);
        expect_v("up_div_entry", 0); expect_v("up_hs_in_div", 0); expect_v("up_busy", 1);
        obs_q.push_back(bus.cpuclk_div_sel); obs_q.push_back(bus.hsclk_sel); obs_q.push_back(bus.busy);
        expect_v("up_div_cycles", D);
        wait_lvl(0, 1'b1, n); obs_q.push_back(n);
        expect_v("up_raise_cycles", S);
        wait_lvl(2, 1'b0, n); obs_q.push_back(n);
        expect_v("up_hs_final", 1); expect_v("up_div_final", 0);
        obs_q.push_back(bus.hsclk_sel); obs_q.push_back(bus.cpuclk_div_sel);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.val) begin bad++; $display("FAIL %s got=%0d want=%0d", e.tag, o, e.val); end
        end
    endtask

    task automatic test_div_change();
        exp_t e;
        integer o;
        int n;
        logic r;
        expect_v("dc_ready", 1);
        send_req(1'b1, DIV4, r);
        obs_q.push_back(r);
        expect_v("dc_hs_drop", 0); expect_v("dc_div_held", 0);
        obs_q.push_back(bus.hsclk_sel); obs_q.push_back(bus.cpuclk_div_sel);
        expect_v("dc_drop_cycles", S);
        wait_div(DIV4, n); obs_q.push_back(n);
        expect_v("dc_hs_in_div", 0);
        obs_q.push_back(bus.hsclk_sel);
        expect_v("dc_div_cycles", D);
        wait_lvl(0, 1'b1, n); obs_q.push_back(n);
        expect_v("dc_raise_cycles", S);
        wait_lvl(2, 1'b0, n); obs_q.push_back(n);
        expect_v("dc_div_final", 2); expect_v("dc_hs_final", 1);
        obs_q.push_back(bus.cpuclk_div_sel); obs_q.push_back(bus.hsclk_sel);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.val) begin bad++; $display("FAIL %s got=%0d want=%0d", e.tag, o, e.val); end
        end
    endtask

    task automatic test_slow_from_hs();
        exp_t e;
        integer o;
        int n;
        bus.slow_req = 1'b1;
        tick();
        expect_v("sl_hs_drop", 0); expect_v("sl_busy", 1);
        obs_q.push_back(bus.hsclk_sel); obs_q.push_back(bus.busy);
        expect_v("sl_ack_delay", S);
        wait_lvl(1, 1'b1, n); obs_q.push_back(n);
        expect_v("sl_hs_in_slow", 0);
        obs_q.push_back(bus.hsclk_sel);
        repeat (40 - 1 - S) tick();
        expect_v("sl_ack_hold", 1); expect_v("sl_ready", 0); expect_v("sl_busy_hold", 1);
        obs_q.push_back(bus.slow_ack); obs_q.push_back(bus.req_ready); obs_q.push_back(bus.busy);
        bus.slow_req = 1'b0;
        tick();
        expect_v("sl_ack_fall", 0); expect_v("sl_hs_raise", 1);
        obs_q.push_back(bus.slow_ack); obs_q.push_back(bus.hsclk_sel);
        expect_v("sl_raise_cycles", S);
        wait_lvl(2, 1'b0, n); obs_q.push_back(n);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.val) begin bad++; $display("FAIL %s got=%0d want=%0d", e.tag, o, e.val); end
        end
    endtask

    task automatic test_hs_to_ls();
        exp_t e;
        integer o;
        int n;
        logic r;
        expect_v("dn_ready", 1);
        send_req(1'b0, DIV8, r);
        obs_q.push_back(r);
        expect_v("dn_hs_drop", 0);
        obs_q.push_back(bus.hsclk_sel);
        expect_v("dn_drop_div_cycles", S + D);
        wait_lvl(2, 1'b0, n); obs_q.push_back(n);
        expect_v("dn_div_final", 3); expect_v("dn_hs_final", 0);
        obs_q.push_back(bus.cpuclk_div_sel); obs_q.push_back(bus.hsclk_sel);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.val) begin bad++; $display("FAIL %s got=%0d want=%0d", e.tag, o, e.val); end
        end
    endtask

    task automatic test_slow_vs_req();
        exp_t e;
        integer o;
        int n;
        bus.req_valid = 1'b1; bus.req_hs = 1'b0; bus.req_div = DIV2; bus.slow_req = 1'b1;
        #1;
        expect_v("sv_ready_blocked", 0);
        obs_q.push_back(bus.req_ready);
        tick();
        expect_v("sv_ack", 1); expect_v("sv_div_held", 3); expect_v("sv_busy", 0);
        obs_q.push_back(bus.slow_ack); obs_q.push_back(bus.cpuclk_div_sel); obs_q.push_back(bus.busy);
        repeat (4) tick();
        expect_v("sv_div_still", 3); expect_v("sv_ack_still", 1);
        obs_q.push_back(bus.cpuclk_div_sel); obs_q.push_back(bus.slow_ack);
        bus.slow_req = 1'b0;
        #1;
        expect_v("sv_ready_after", 1);
        obs_q.push_back(bus.req_ready);
        tick();
        bus.req_valid = 1'b0;
        expect_v("sv_ack_fall", 0); expect_v("sv_div_new", 1); expect_v("sv_busy_div", 1);
        obs_q.push_back(bus.slow_ack); obs_q.push_back(bus.cpuclk_div_sel); obs_q.push_back(bus.busy);
        expect_v("sv_div_cycles", D);
        wait_lvl(2, 1'b0, n); obs_q.push_back(n);
        expect_v("sv_hs_final", 0);
        obs_q.push_back(bus.hsclk_sel);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.val) begin bad++; $display("FAIL %s got=%0d want=%0d", e.tag, o, e.val); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        integer o;
        logic r;
        expect_v("rm_ready", 1);
        send_req(1'b1, DIV1, r);
        obs_q.push_back(r);
        expect_v("rm_div_entry", 0);
        obs_q.push_back(bus.cpuclk_div_sel);
        repeat (D - 1 - 7) tick();
        rst = 1'b1;
        #1;
        expect_v("rm_hs", 0); expect_v("rm_div", 3); expect_v("rm_ack", 0); expect_v("rm_busy", 0);
        obs_q.push_back(bus.hsclk_sel); obs_q.push_back(bus.cpuclk_div_sel);
        obs_q.push_back(bus.slow_ack); obs_q.push_back(bus.busy);
        tick();
        rst = 1'b0;
        repeat (D + S) tick();
        expect_v("rm_idle_busy", 0); expect_v("rm_idle_hs", 0); expect_v("rm_idle_div", 3);
        obs_q.push_back(bus.busy); obs_q.push_back(bus.hsclk_sel); obs_q.push_back(bus.cpuclk_div_sel);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.val) begin bad++; $display("FAIL %s got=%0d want=%0d", e.tag, o, e.val); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        integer o;
        int n;
        logic r;
        expect_v("bb_ready1", 1);
        send_req(1'b1, DIV8, r);
        obs_q.push_back(r);
        expect_v("bb_hs_direct", 1);
        obs_q.push_back(bus.hsclk_sel);
        bus.slow_req = 1'b1;
        expect_v("bb_slow_in_raise", 2 * S + 1);
        wait_lvl(1, 1'b1, n); obs_q.push_back(n);
        bus.slow_req = 1'b0;
        tick();
        expect_v("bb_reraise", S);
        wait_lvl(2, 1'b0, n); obs_q.push_back(n);
        expect_v("bb_ready2", 1);
        send_req(1'b1, DIV8, r);
        obs_q.push_back(r);
        expect_v("bb_zero_lat_busy", 0); expect_v("bb_zero_lat_hs", 1);
        obs_q.push_back(bus.busy); obs_q.push_back(bus.hsclk_sel);
        expect_v("bb_ready3", 1);
        send_req(1'b0, DIV8, r);
        obs_q.push_back(r);
        expect_v("bb_hs_drop", 0);
        obs_q.push_back(bus.hsclk_sel);
        expect_v("bb_drop_only", S);
        wait_lvl(2, 1'b0, n); obs_q.push_back(n);
        expect_v("bb_div_final", 3);
        obs_q.push_back(bus.cpuclk_div_sel);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.val) begin bad++; $display("FAIL %s got=%0d want=%0d", e.tag, o, e.val); end
        end
    endtask

`ifdef CLKSWITCH_COUNT_EN
    task automatic test_count();
        exp_t e;
        integer o;
        int n;
        logic r;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_v("cnt_reset", 0);
        obs_q.push_back(bus.switch_count);
        for (int i = 0; i < 3; i++) begin
            send_req(1'b1, DIV8, r);
            wait_lvl(2, 1'b0, n);
            send_req(1'b0, DIV8, r);
            wait_lvl(2, 1'b0, n);
        end
        expect_v("cnt_three", 3);
        obs_q.push_back(bus.switch_count);
        force dut.switch_cnt = 16'hFFFF;
        tick();
        release dut.switch_cnt;
        send_req(1'b1, DIV8, r);
        wait_lvl(2, 1'b0, n);
        expect_v("cnt_saturate", 16'hFFFF);
        obs_q.push_back(bus.switch_count);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.val) begin bad++; $display("FAIL %s got=%0d want=%0d", e.tag, o, e.val); end
        end
    endtask
`endif

    task automatic test_invariants();
        total++;
        if (div_viol !== 0) begin bad++; $display("FAIL div_while_fast got=%0d want=0", div_viol); end
        total++;
        if (tog_viol !== 0) begin bad++; $display("FAIL hs_toggle_spacing got=%0d want=0", tog_viol); end
    endtask

    initial begin
        test_reset();
        test_ls_to_hs();
        test_div_change();
        test_slow_from_hs();
        test_hs_to_ls();
        test_slow_vs_req();
        test_reset_mid();
        test_back_to_back();
`ifdef CLKSWITCH_COUNT_EN
        test_count();
`endif
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clkswitch_seq.md
Name: clkswitch_seq

Overview:
- Sequencer that drives the CPU clock controller's hsclk_sel and cpuclk_div_sel inputs, on the high-speed clock.
- Never changes the divider while the high-speed clock is selected.
- Waits fixed settle times around every select change.
- Temporarily drops to the low-speed (host bus) clock for slow accesses flagged by address decode, with a level handshake.

Parameters:
SETTLE_CYCLES, 16, hsclk cycles held after any hsclk_sel change (covers async switch resynchronisation); legal 1..255
DIV_SETTLE, 16, hsclk cycles held after a divider change (must be at least 2x the slowest divide ratio); legal 1..255

Ports:
hsclk_in  input  1  high-speed clock; all state on rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  1  configuration request valid
req_hs  input  1  requested mode: 1 = high-speed, 0 = low-speed
req_div  input  2  requested divider: 00 /1, 01 /2, 10 /4, 11 /8
req_ready  output  1  request accepted on a cycle where req_valid and req_ready are both high
slow_req  input  1  level: current access needs the low-speed clock
slow_ack  output  1  level: low-speed clock selected and settled for slow_req
hsclk_sel  output  1  to clock controller
cpuclk_div_sel  output  2  to clock controller
busy  output  1  high in any non-idle state

Behaviour:
- Reset values: state LS_IDLE, hsclk_sel 0, cpuclk_div_sel 2'b11, slow_ack 0, busy 0, cfg_hs 0, cfg_div 2'b11, count 0, ret_hs 0. All outputs are registered except req_ready.
- req_ready = (state is LS_IDLE or HS_IDLE) && !slow_req.
- On accept, cfg_hs and cfg_div load from req_hs and req_div.
- Timed states:
  - Each timed state loads count = N-1 on entry, decrements each cycle and exits when count == 0.
  - A timed state therefore lasts exactly N cycles.
  - Timed states are DROP (SETTLE_CYCLES), DIV (DIV_SETTLE) and RAISE (SETTLE_CYCLES).
- States and transitions:
  - LS_IDLE (hsclk_sel=0):
    - slow_req high -> slow_ack=1 from the next cycle.
    - Accept with req_div != cpuclk_div_sel -> DIV; cpuclk_div_sel updates on the DIV entry edge.
    - Accept with same divider and req_hs=1 -> RAISE.
    - Otherwise stay.
  - HS_IDLE (hsclk_sel=1):
    - slow_req -> DROP with ret_hs=1.
    - Accept with req_hs=1 and same divider -> stay; zero-latency ack.
    - Any other accept -> DROP with ret_hs=0.
  - DROP: hsclk_sel=0. At exit:
    - ret_hs=1 -> SLOW.
    - Divider change pending -> DIV.
    - Otherwise cfg_hs ? RAISE : LS_IDLE.
  - DIV: at exit, cfg_hs ? (slow_req ? SLOW with ret_hs=1 : RAISE) : LS_IDLE.
  - SLOW: hsclk_sel=0, slow_ack=1. When slow_req falls, slow_ack=0 on the next cycle and go to RAISE. ret_hs clears.
  - RAISE: hsclk_sel=1 on the entry edge; at exit -> HS_IDLE.
    - slow_req raised during RAISE is honoured from HS_IDLE once RAISE completes.
- Invariants:
  - cpuclk_div_sel changes only when hsclk_sel has been 0 for at least SETTLE_CYCLES, or in LS_IDLE.
  - hsclk_sel never toggles twice within SETTLE_CYCLES.
- Boundary conditions:
  - slow_req dropping in LS_IDLE: slow_ack falls the next cycle.
  - req_valid and slow_req arriving together: slow_req wins (req_ready=0).
  - Requests are ignored outside idle states; the requester must hold req_valid.
  - Reset mid-sequence: immediate return to LS_IDLE / slowest divider, whatever the current state.

Optional Feature:
- CLKSWITCH_COUNT_EN defined:
  - Adds output switch_count[15:0], reset 0.
  - Increments on every RAISE entry; saturates at 16'hFFFF.
- CLKSWITCH_COUNT_EN undefined: port and counter are absent.

Decomposition:
- Shared package clkswitch_pkg holds:
  - state enum: LS_IDLE, HS_IDLE, DROP, DIV, RAISE, SLOW
  - divider codes: DIV1=00, DIV2=01, DIV4=10, DIV8=11
  - CNT_W=8
- One natural sub-module: settle_timer (load/decrement/zero-flag counter), instanced once and shared by all timed states.

Test Plan:
- Reset, then req hs=1 div=00 -> req_ready=1 accept; DIV for 16 cycles with div_sel=00; RAISE 16 cycles; hsclk_sel=1 at cycle 17 after accept; HS_IDLE, busy=0.
- From HS_IDLE div=00, req hs=1 div=10 -> DROP 16 (hsclk_sel=0), div_sel=10 only after DROP, DIV 16, RAISE 16; assert div_sel never changes while hsclk_sel=1.
- HS_IDLE, pulse slow_req high 40 cycles -> slow_ack=1 after 16 cycles of hsclk_sel=0; slow_ack falls 1 cycle after slow_req drops; hsclk_sel=1 again after 16-cycle RAISE.
- LS_IDLE, req_valid and slow_req asserted together -> req_ready=0, slow_ack=1 next cycle; request accepted only after slow_req drops.
- Assert rst during DIV (count=7) -> asynchronously hsclk_sel=0, div_sel=11, slow_ack=0, busy=0.
- CLKSWITCH_COUNT_EN: three LS->HS transitions -> switch_count=3; force the count to FFFF, then one more RAISE -> switch_count stays FFFF.
